// File: rtl/task_1_out_if.sv
// AXI-Stream link carrying framed task output words from task_1_out to the downstream consumer.
interface task_1_out_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] o_tdata;
   logic                  o_tvalid;
   logic                  o_tlast;
   logic                  i_tready;

   modport master (output o_tdata, output o_tvalid, output o_tlast, input i_tready);
   modport slave  (input o_tdata, input o_tvalid, input o_tlast, output i_tready);
endinterface

// File: rtl/task_1_out.sv
// Store-and-forward output framer: buffers NUM_WORDS core words, then streams them as one
// AXI-Stream frame with a registered output stage backed by a one-word prefetch.
module task_1_out #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 243,
   parameter int ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_enb,
   task_1_out_if.master          axis,
   output logic                  o_output_last,
   output logic                  o_busy,
   output logic                  o_overflow
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_SEND    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state_r;
   logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];
   logic [DATA_WIDTH-1:0] mem_q_r;
   logic [ADDR_WIDTH-1:0] wr_cnt_r;
   logic [ADDR_WIDTH-1:0] rd_cnt_r;
   logic                  rd_all_r;
   logic                  rd_pend_r;
   logic                  rd_last_r;
   logic [DATA_WIDTH-1:0] pf_data_r;
   logic                  pf_last_r;
   logic                  pf_vld_r;
   logic [DATA_WIDTH-1:0] tdata_r;
   logic                  tvalid_r;
   logic                  tlast_r;
   logic                  output_last_r;
   logic                  busy_r;
   logic                  overflow_r;

   logic accept_s;
   logic xfer_s;
   logic out_free_s;
   logic held_s;
   logic issue_s;

   // Handshake decode; a read is issued only when the output register and prefetch can absorb it
   always_comb begin
      accept_s   = 1'b0;
      xfer_s     = tvalid_r & axis.i_tready;
      out_free_s = ~tvalid_r | axis.i_tready;
      held_s     = tvalid_r & ~axis.i_tready;
      issue_s    = 1'b0;
      if ((state_r == ST_IDLE) || (state_r == ST_COLLECT)) begin
         accept_s = i_enb;
      end else begin
         accept_s = 1'b0;
      end
      if ((state_r == ST_SEND) && !rd_all_r) begin
         issue_s = ~((held_s & pf_vld_r) | (held_s & rd_pend_r) | (pf_vld_r & rd_pend_r));
      end else begin
         issue_s = 1'b0;
      end
   end

   // Frame buffer with registered read port
   always_ff @(posedge i_clk) begin
      if (accept_s) begin
         mem_r[wr_cnt_r] <= i_data;
      end
      if (issue_s) begin
         mem_q_r <= mem_r[rd_cnt_r];
      end
   end

   // Control FSM, read pipeline and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r       <= ST_IDLE;
         wr_cnt_r      <= {ADDR_WIDTH{1'b0}};
         rd_cnt_r      <= {ADDR_WIDTH{1'b0}};
         rd_all_r      <= 1'b0;
         rd_pend_r     <= 1'b0;
         rd_last_r     <= 1'b0;
         pf_data_r     <= {DATA_WIDTH{1'b0}};
         pf_last_r     <= 1'b0;
         pf_vld_r      <= 1'b0;
         tdata_r       <= {DATA_WIDTH{1'b0}};
         tvalid_r      <= 1'b0;
         tlast_r       <= 1'b0;
         output_last_r <= 1'b0;
         busy_r        <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         rd_pend_r <= issue_s;
         rd_last_r <= issue_s && (rd_cnt_r == LAST_ADDR);
         if (issue_s) begin
            if (rd_cnt_r == LAST_ADDR) begin
               rd_cnt_r <= {ADDR_WIDTH{1'b0}};
               rd_all_r <= 1'b1;
            end else begin
               rd_cnt_r <= rd_cnt_r + ADDR_WIDTH'(1);
            end
         end

         // Prefetch feeds the output register first so beats stay in order
         if (out_free_s) begin
            if (pf_vld_r) begin
               tdata_r  <= pf_data_r;
               tlast_r  <= pf_last_r;
               tvalid_r <= 1'b1;
               if (rd_pend_r) begin
                  pf_data_r <= mem_q_r;
                  pf_last_r <= rd_last_r;
               end else begin
                  pf_vld_r <= 1'b0;
               end
            end else if (rd_pend_r) begin
               tdata_r  <= mem_q_r;
               tlast_r  <= rd_last_r;
               tvalid_r <= 1'b1;
            end else begin
               tvalid_r <= 1'b0;
               tlast_r  <= 1'b0;
            end
         end else if (rd_pend_r) begin
            pf_data_r <= mem_q_r;
            pf_last_r <= rd_last_r;
            pf_vld_r  <= 1'b1;
         end

         if (i_enb && ((state_r == ST_SEND) || (state_r == ST_DONE))) begin
            overflow_r <= 1'b1;
         end

         case (state_r)
            ST_IDLE, ST_COLLECT: begin
               output_last_r <= 1'b0;
               if (accept_s) begin
                  busy_r <= 1'b1;
                  if (wr_cnt_r == LAST_ADDR) begin
                     wr_cnt_r <= {ADDR_WIDTH{1'b0}};
                     state_r  <= ST_SEND;
                  end else begin
                     wr_cnt_r <= wr_cnt_r + ADDR_WIDTH'(1);
                     state_r  <= ST_COLLECT;
                  end
               end
            end
            ST_SEND: begin
               if (xfer_s && tlast_r) begin
                  state_r       <= ST_DONE;
                  output_last_r <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r       <= ST_IDLE;
               output_last_r <= 1'b0;
               busy_r        <= 1'b0;
               rd_all_r      <= 1'b0;
            end
            default: begin
               state_r       <= ST_IDLE;
               output_last_r <= 1'b0;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   assign axis.o_tdata  = tdata_r;
   assign axis.o_tvalid = tvalid_r;
   assign axis.o_tlast  = tlast_r;
   assign o_output_last = output_last_r;
   assign o_busy        = busy_r;
   assign o_overflow    = overflow_r;
endmodule

// File: doc/task_1_out.md
# task_1_out

Output-side framing block for the task pipeline. It collects NUM_WORDS processed words from the task core (`i_data` qualified by `i_enb`) into an internal store-and-forward buffer. Once the full frame is buffered, it transmits the frame as an AXI-Stream master (`o_tdata`/`o_tvalid`/`o_tlast`, honouring `i_tready`). After the last beat is accepted it pulses `o_output_last`, which the input block uses to request the next frame.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width on both the core side and the stream side.
- `NUM_WORDS`, 243: words per frame; legal range is 1 or more.
- `ADDR_WIDTH`, $clog2(NUM_WORDS) (minimum 1): buffer address width. Buffer depth is NUM_WORDS.

Ports:
- `i_clk`  in  1  sole clock; all logic on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_data`  in  DATA_WIDTH  processed word from the task core.
- `i_enb`  in  1  write strobe for `i_data`; one word per cycle when high.
- `i_tready`  in  1  downstream stream ready.
- `o_tdata`  out  DATA_WIDTH  stream data.
- `o_tvalid`  out  1  stream valid.
- `o_tlast`  out  1  high on the final beat of a frame.
- `o_output_last`  out  1  one-cycle pulse after the final beat is accepted.
- `o_busy`  out  1  high in COLLECT, SEND and DONE.
- `o_overflow`  out  1  sticky error flag: a word arrived while the block was not accepting.

## Operation
- States:
  - IDLE: write count = 0.
  - COLLECT: storing words.
  - SEND: streaming the frame.
  - DONE: one cycle, raises the frame-end pulse.
- Write side: `wr_cnt` runs from 0 to NUM_WORDS-1. A word is accepted when `i_enb`=1 in IDLE or COLLECT; it is written to buffer[`wr_cnt`] and `wr_cnt` increments.
- IDLE → COLLECT on the first accepted word when NUM_WORDS > 1.
- IDLE/COLLECT → SEND on the accepted word where `wr_cnt`==NUM_WORDS-1. `wr_cnt` resets to 0. With NUM_WORDS=1 the first word goes straight to SEND.
- `i_enb`=1 in SEND or DONE: the word is dropped, buffer contents are unaffected, and `o_overflow` is set. `o_overflow` clears only on reset.
- Read side: `rd_cnt` runs from 0 to NUM_WORDS-1. The buffer has registered (1-cycle) read. An output register holds the presented beat, and a one-word prefetch keeps `o_tdata` stable under backpressure and allows full throughput.
- A beat transfers when `o_tvalid` && `i_tready`. After each transfer the next word is presented in the immediately following cycle; there are no bubbles while `i_tready` stays high.
- `o_tlast` = 1 exactly when the presented beat is index NUM_WORDS-1.
- SEND → DONE on transfer of the last beat. In DONE: `o_tvalid`=0 and `o_output_last`=1. DONE → IDLE unconditionally.
- Data order: output order equals input order; no reordering, no modification.

## Timing
- Reset value of every output is 0. On reset, state returns to IDLE, both counters clear and the prefetch is emptied.
- Reset mid-frame (COLLECT or SEND) discards the partial frame. After release, the next accepted word is index 0 of a new frame.
- Latency: `o_tvalid` rises 2 cycles after the edge that captures the last input word (edge+1 enters SEND and issues the read; edge+2 has data in the output register).
- `o_tvalid`, `o_tdata` and `o_tlast` are registered. Once `o_tvalid` is asserted, these signals do not change until the beat transfers (AXI rule).
- `o_tvalid` is never deasserted mid-frame; it stays high from the first beat through the accepted last beat.
- Throughput: with `i_tready` held at 1, the frame occupies exactly NUM_WORDS consecutive `o_tvalid` cycles.
- `o_output_last` is high for exactly one cycle, the cycle after the last-beat handshake. The next frame's first word is accepted starting the cycle after that (IDLE).
- `o_busy` is a registered decode of state; it is 0 only in IDLE.

## Test plan
- Basic frame: NUM_WORDS=4, write 0x11,0x22,0x33,0x44 on consecutive cycles, `i_tready`=1 → beats 0x11..0x44 on 4 consecutive cycles. `o_tvalid` first rises 2 cycles after the 0x44 write edge. `o_tlast` is high only with 0x44. `o_output_last` pulses once, one cycle later.
- Backpressure: same frame, `i_tready` toggling 1,0,0,1,0,1,1 → `o_tdata` is held constant during stalls, no beat is duplicated or lost, and the sequence is 0x11..0x44.
- Gapped input: NUM_WORDS=243, `i_enb` high every third cycle with data = index → no output until word 242 is written. Then 243 beats 0..242 are output, with `o_tlast` on 242 (0xF2).
- Overflow: during SEND, pulse `i_enb` with 0xAA → `o_overflow`=1 and stays 1. The streamed frame is unchanged. The next frame still works.
- Reset mid-SEND: assert `i_rst` asynchronously after 2 of 4 beats → all outputs 0 immediately. After release, a new 4-word frame streams correctly starting at its own word 0.
- NUM_WORDS=1: single write 0x5A → one beat 0x5A with `o_tvalid`=`o_tlast`=1, then an `o_output_last` pulse.
